// File: rtl/mult_div_unit.sv
// mult_div_unit
// Iterative multiply/divide unit for the execute stage. Multiply is radix-4
// Booth over WIDTH+2-bit extended operands (WIDTH/2+1 iterations). Divide is
// restoring division on operand magnitudes, followed by a one-cycle sign
// fix-up. Results are returned as hi/lo words together with a one-cycle done
// pulse. hi/lo hold the last result until the next one is written.
//
// Optional feature: define MULTDIV_DIV_EN to build the divider (DIV/FIXUP
// datapath, div_by_zero). Without it, op=0 completes in two cycles with
// hi=lo=0, and div_by_zero is tied low.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   start         request strobe (see accept rule below)
//   op            1 = multiply, 0 = divide
//   signed_op     1 = two's-complement operands, 0 = unsigned
//   src_a, src_b  multiplicand/dividend, multiplier/divisor
//   busy          operation in flight (MULT, DIV, FIXUP)
//   done          one-cycle completion pulse; hi/lo valid from this cycle
//   hi, lo        product upper/lower half, or remainder/quotient
//   div_by_zero   last divide had src_b == 0; cleared on the next accept
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int MW = WIDTH + 2;               // extended operand width
    localparam int AW = WIDTH + 4;               // Booth accumulator width (room for +/-2M)
    localparam int CW = $clog2(WIDTH + 1) + 1;
    localparam logic [CW-1:0] MULT_LAST = CW'(WIDTH / 2);

    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIXUP, S_DONE} state_t;

    state_t         state, next_state;
    logic [CW-1:0]  cnt;
    logic [MW-1:0]  mcand;     // extended src_a; also holds dividend and its sign
    logic [MW-1:0]  mplier;    // extended src_b; low product half during multiply
    logic [AW-1:0]  acc;
    logic           qm1;
    logic           accept;

    logic [AW-1:0]  m_ext, addend, acc_sum, acc_nxt;
    logic [MW-1:0]  mplier_nxt;

    // Handshake: start is a request with no ready signal. It is accepted only
    // on an edge where the unit is in IDLE or DONE (busy low); a start seen
    // while busy is dropped, not queued. Completion is signalled by done.
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

    // Booth digit from {b[2i+1], b[2i], b[2i-1]}, then arithmetic shift by 2
    // of the whole {acc, mplier, qm1} chain.
    always_comb begin
        m_ext = {{2{mcand[MW-1]}}, mcand};
        case ({mplier[1:0], qm1})
            3'b001, 3'b010: addend = m_ext;
            3'b011:         addend = m_ext << 1;
            3'b100:         addend = -(m_ext << 1);
            3'b101, 3'b110: addend = -m_ext;
            default:        addend = '0;
        endcase
        acc_sum    = acc + addend;
        acc_nxt    = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
        mplier_nxt = {acc_sum[1:0], mplier[MW-1:2]};
    end

`ifdef MULTDIV_DIV_EN
    localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH);

    logic [WIDTH-1:0] rem, quot, dvsr;
    logic [WIDTH-1:0] a_mag, b_mag, rem_nxt, quot_nxt, q_fix, r_fix;
    logic [WIDTH:0]   shl, diff;
    logic             a_neg, b_neg, dbz_q;

    // Extension bits are the operand signs for signed ops and zero otherwise.
    always_comb begin
        a_neg    = mcand[MW-1];
        b_neg    = mplier[MW-1];
        a_mag    = a_neg ? (WIDTH'(0) - mcand[WIDTH-1:0]) : mcand[WIDTH-1:0];
        b_mag    = b_neg ? (WIDTH'(0) - mplier[WIDTH-1:0]) : mplier[WIDTH-1:0];
        shl      = {rem, quot[WIDTH-1]};
        diff     = shl - {1'b0, dvsr};
        // diff[WIDTH] set means the trial subtraction went negative: restore.
        rem_nxt  = diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], ~diff[WIDTH]};
        q_fix    = (a_neg ^ b_neg) ? (WIDTH'(0) - quot) : quot;
        r_fix    = a_neg ? (WIDTH'(0) - rem) : rem;
    end

    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (start) next_state = op ? S_MULT : S_DIV;
            S_MULT:  if (cnt == MULT_LAST) next_state = S_DONE;
`ifdef MULTDIV_DIV_EN
            // cnt == 0 is the setup cycle (zero-divisor check, magnitudes).
            S_DIV: begin
                if (cnt == '0) begin
                    if (mplier[WIDTH-1:0] == '0) next_state = S_DONE;
                end else if (cnt == DIV_LAST) begin
                    next_state = S_FIXUP;
                end
            end
            S_FIXUP: next_state = S_DONE;
`else
            S_DIV:   next_state = S_DONE;
`endif
            S_DONE:  next_state = start ? (op ? S_MULT : S_DIV) : S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            qm1    <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rem    <= '0;
            quot   <= '0;
            dvsr   <= '0;
            dbz_q  <= 1'b0;
`endif
        end else begin
            busy <= (next_state == S_MULT) || (next_state == S_DIV) || (next_state == S_FIXUP);
            done <= (next_state == S_DONE);
            if (accept) begin
                mcand  <= signed_op ? {{2{src_a[WIDTH-1]}}, src_a} : {2'b00, src_a};
                mplier <= signed_op ? {{2{src_b[WIDTH-1]}}, src_b} : {2'b00, src_b};
                acc    <= '0;
                qm1    <= 1'b0;
                cnt    <= '0;
`ifdef MULTDIV_DIV_EN
                dbz_q  <= 1'b0;
`endif
            end else begin
                case (state)
                    S_MULT: begin
                        acc    <= acc_nxt;
                        mplier <= mplier_nxt;
                        qm1    <= mplier[1];
                        cnt    <= cnt + 1'b1;
                        if (cnt == MULT_LAST) begin
                            hi <= {acc_nxt[WIDTH-3:0], mplier_nxt[MW-1:WIDTH]};
                            lo <= mplier_nxt[WIDTH-1:0];
                        end
                    end
`ifdef MULTDIV_DIV_EN
                    S_DIV: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == '0) begin
                            if (mplier[WIDTH-1:0] == '0) begin
                                hi    <= mcand[WIDTH-1:0];
                                lo    <= '1;
                                dbz_q <= 1'b1;
                            end
                            rem  <= '0;
                            quot <= a_mag;
                            dvsr <= b_mag;
                        end else begin
                            rem  <= rem_nxt;
                            quot <= quot_nxt;
                        end
                    end
                    S_FIXUP: begin
                        hi <= r_fix;
                        lo <= q_fix;
                    end
`else
                    S_DIV: begin
                        hi <= '0;
                        lo <= '0;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: WIDTH=8/32/64 instances share one stimulus bus.
// Directed table for WIDTH=32, random operands against an arithmetic model
// for all three widths, and hand sequences for ignored start, back-to-back
// and mid-operation reset.
module tb_mult_div_unit;

  localparam int WINDOW = 72;

  logic        clk;
  logic        reset, start, op, signed_op;
  logic [63:0] src_a, src_b;

  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;
  logic        busy64, done64, dbz64;
  logic [63:0] hi64, lo64;

  mult_div_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .src_a(src_a[7:0]), .src_b(src_b[7:0]), .busy(busy8), .done(done8),
    .hi(hi8), .lo(lo8), .div_by_zero(dbz8));

  mult_div_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .src_a(src_a[31:0]), .src_b(src_b[31:0]), .busy(busy32), .done(done32),
    .hi(hi32), .lo(lo32), .div_by_zero(dbz32));

  mult_div_unit #(.WIDTH(64)) u64 (
    .clk(clk), .reset(reset), .start(start), .op(op), .signed_op(signed_op),
    .src_a(src_a), .src_b(src_b), .busy(busy64), .done(done64),
    .hi(hi64), .lo(lo64), .div_by_zero(dbz64));

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-width views of the outputs: index 0 = 8, 1 = 32, 2 = 64.
  logic [63:0] hi_a [3];
  logic [63:0] lo_a [3];
  logic        busy_a [3];
  logic        done_a [3];
  logic        dbz_a [3];
  assign hi_a[0] = {56'd0, hi8};
  assign hi_a[1] = {32'd0, hi32};
  assign hi_a[2] = hi64;
  assign lo_a[0] = {56'd0, lo8};
  assign lo_a[1] = {32'd0, lo32};
  assign lo_a[2] = lo64;
  assign busy_a[0] = busy8;
  assign busy_a[1] = busy32;
  assign busy_a[2] = busy64;
  assign done_a[0] = done8;
  assign done_a[1] = done32;
  assign done_a[2] = done64;
  assign dbz_a[0] = dbz8;
  assign dbz_a[1] = dbz32;
  assign dbz_a[2] = dbz64;

  int wv [3] = '{8, 32, 64};

  int total = 0;
  int bad   = 0;

  // Results captured by run_op.
  int          dcyc [3];
  int          dcnt [3];
  logic [63:0] rhi [3];
  logic [63:0] rlo [3];
  logic        rdbz [3];
  bit          busy_err [3];

  // Scoreboard for the hand sequences on the 32-bit instance.
  logic [63:0] exp_q [$];
  int          cyc_q [$];

  typedef struct {
    bit          o;
    bit          s;
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
    int          lat;
  } vec_t;

  vec_t vt [10];

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic logic signed [129:0] ext(input logic [63:0] v, input int w, input bit s);
    logic signed [129:0] r;
    r = '0;
    for (int i = 0; i < 130; i++) r[i] = (i < w) ? v[i] : (s & v[w-1]);
    return r;
  endfunction

  // Reference: plain arithmetic on exact integers, then truncation to w bits.
  function automatic void model(input int w, input bit o, input bit s,
                                input logic [63:0] a, input logic [63:0] b,
                                output logic [63:0] eh, output logic [63:0] el,
                                output bit edbz, output int lat);
    logic [63:0]         m;
    logic signed [129:0] xa, xb, p, q, rr;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    xa = ext(a & m, w, s);
    xb = ext(b & m, w, s);
    edbz = 1'b0;
    if (o) begin
      p   = xa * xb;
      el  = p[63:0] & m;
      q   = p >>> w;
      eh  = q[63:0] & m;
      lat = w / 2 + 2;
    end else begin
`ifdef MULTDIV_DIV_EN
      if ((b & m) == 64'd0) begin
        el   = m;
        eh   = a & m;
        edbz = 1'b1;
        lat  = 2;
      end else begin
        q   = xa / xb;
        rr  = xa % xb;
        el  = q[63:0] & m;
        eh  = rr[63:0] & m;
        lat = w + 3;
      end
`else
      el  = 64'd0;
      eh  = 64'd0;
      lat = 2;
`endif
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents a request so that the next rising edge (cycle 0) samples it.
  task automatic launch(input bit o, input bit s, input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    op = o; signed_op = s; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_op(input bit o, input bit s, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eh [3];
    logic [63:0] el [3];
    bit          ed [3];
    int          lat [3];
    for (int k = 0; k < 3; k++) begin
      model(wv[k], o, s, a, b, eh[k], el[k], ed[k], lat[k]);
      dcyc[k] = -1; dcnt[k] = 0; busy_err[k] = 1'b0;
    end
    launch(o, s, a, b);
    for (int cyc = 1; cyc <= WINDOW; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (busy_a[k] !== (cyc < lat[k])) busy_err[k] = 1'b1;
        if (done_a[k] === 1'b1) begin
          dcnt[k]++;
          if (dcyc[k] < 0) begin
            dcyc[k] = cyc; rhi[k] = hi_a[k]; rlo[k] = lo_a[k]; rdbz[k] = dbz_a[k];
          end
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w%0d op%0d done count", wv[k], o), 64'(dcnt[k]), 64'd1);
      check($sformatf("w%0d op%0d done cycle", wv[k], o), 64'(dcyc[k]), 64'(lat[k]));
      check($sformatf("w%0d op%0d busy profile", wv[k], o), 64'(busy_err[k]), 64'd0);
      check($sformatf("w%0d op%0d hi a=%0h b=%0h", wv[k], o, a, b), rhi[k], eh[k]);
      check($sformatf("w%0d op%0d lo a=%0h b=%0h", wv[k], o, a, b), rlo[k], el[k]);
      check($sformatf("w%0d op%0d div_by_zero", wv[k], o), 64'(rdbz[k]), 64'(ed[k]));
      check($sformatf("w%0d op%0d lo hold", wv[k], o), lo_a[k], el[k]);
      check($sformatf("w%0d op%0d dbz hold", wv[k], o), 64'(dbz_a[k]), 64'(ed[k]));
    end
  endtask

  // Watches the 32-bit instance for ncyc cycles after a launch, matching each
  // done against exp_q/cyc_q; optionally pulses start or reset on one cycle.
  task automatic watch(input int ncyc, input int pulse_cyc, input bit o2, input bit s2,
                       input logic [63:0] a2, input logic [63:0] b2, input int rst_cyc,
                       input bit busy_at_rst);
    logic [63:0] e;
    int          c;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(negedge clk);
      if (done32 === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected done: cycle=%0d hi=%0h lo=%0h", cyc, hi32, lo32);
        end else begin
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          check("seq done cycle", 64'(cyc), 64'(c));
          check("seq result", {hi32, lo32}, e);
        end
      end
      if (cyc == rst_cyc) check("busy before reset", 64'(busy32), 64'(busy_at_rst));
      if (cyc == rst_cyc + 1) begin
        check("post-reset busy", 64'(busy32), 64'd0);
        check("post-reset done", 64'(done32), 64'd0);
        check("post-reset hi", 64'(hi32), 64'd0);
        check("post-reset lo", 64'(lo32), 64'd0);
        check("post-reset dbz", 64'(dbz32), 64'd0);
      end
      start = 1'b0;
      reset = 1'b0;
      if (cyc == pulse_cyc) begin
        op = o2; signed_op = s2; src_a = a2; src_b = b2; start = 1'b1;
      end
      if (cyc == rst_cyc) reset = 1'b1;
    end
    check("seq pending results", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    cyc_q.delete();
  endtask

  // ---------------- test ----------------
  initial begin
    logic [63:0] a, b;
    bit          o, s;
    int          sel;

    reset = 1'b1; start = 1'b0; op = 1'b0; signed_op = 1'b0;
    src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("w%0d reset busy", wv[k]), 64'(busy_a[k]), 64'd0);
      check($sformatf("w%0d reset done", wv[k]), 64'(done_a[k]), 64'd0);
      check($sformatf("w%0d reset hi", wv[k]), hi_a[k], 64'd0);
      check($sformatf("w%0d reset lo", wv[k]), lo_a[k], 64'd0);
      check($sformatf("w%0d reset dbz", wv[k]), 64'(dbz_a[k]), 64'd0);
    end
    reset = 1'b0;

    // Directed WIDTH=32 table: op, signed, a, b, hi, lo, dbz, done cycle.
    vt[0] = '{1'b1, 1'b0, 64'hFFFFFFFF, 64'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 18};
    vt[1] = '{1'b1, 1'b1, 64'hFFFFFFFD, 64'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 18};
    vt[2] = '{1'b1, 1'b0, 64'hFFFFFFFD, 64'd7,        32'h00000006, 32'hFFFFFFEB, 1'b0, 18};
    vt[3] = '{1'b0, 1'b1, 64'hFFFFFFF9, 64'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 35};
    vt[4] = '{1'b0, 1'b1, 64'h80000000, 64'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 35};
    vt[5] = '{1'b0, 1'b0, 64'h1234,     64'd0,        32'h00001234, 32'hFFFFFFFF, 1'b1, 2};
    vt[6] = '{1'b0, 1'b0, 64'd100,      64'd7,        32'd2,        32'd14,       1'b0, 35};
    vt[7] = '{1'b0, 1'b1, 64'd7,        64'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 35};
    vt[8] = '{1'b1, 1'b1, 64'h80000000, 64'h80000000, 32'h40000000, 32'h00000000, 1'b0, 18};
    vt[9] = '{1'b1, 1'b0, 64'h12345678, 64'd0,        32'h00000000, 32'h00000000, 1'b0, 18};
`ifndef MULTDIV_DIV_EN
    for (int i = 0; i < 10; i++) begin
      if (!vt[i].o) begin
        vt[i].hi = '0; vt[i].lo = '0; vt[i].dbz = 1'b0; vt[i].lat = 2;
      end
    end
`endif
    for (int i = 0; i < 10; i++) begin
      run_op(vt[i].o, vt[i].s, vt[i].a, vt[i].b);
      check($sformatf("vec%0d hi", i), rhi[1], 64'(vt[i].hi));
      check($sformatf("vec%0d lo", i), rlo[1], 64'(vt[i].lo));
      check($sformatf("vec%0d dbz", i), 64'(rdbz[1]), 64'(vt[i].dbz));
      check($sformatf("vec%0d cycle", i), 64'(dcyc[1]), 64'(vt[i].lat));
    end

    // Random operands against the model, all widths.
    for (int i = 0; i < 30; i++) begin
      o   = 1'($urandom_range(0, 1));
      s   = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 7);
      if (sel == 0) b = 64'd0;
      else if (sel < 4) b = b >> $urandom_range(32, 62);
      run_op(o, s, a, b);
    end

    // start during a multiply is ignored: exactly one done, first result.
    do_reset();
    exp_q.push_back(64'h00000000_00030000); cyc_q.push_back(18);
    launch(1'b1, 1'b0, 64'h1000, 64'h30);
    watch(50, 5, 1'b1, 1'b0, 64'd7, 64'd7, -1, 1'b0);

    // start in the DONE cycle chains the next op with no idle cycle.
    do_reset();
    exp_q.push_back(64'hFFFFFFFF_FFFFFFEB); cyc_q.push_back(18);
    exp_q.push_back(64'h00000001_FFFFFFFE); cyc_q.push_back(36);
    launch(1'b1, 1'b1, 64'hFFFFFFFD, 64'd7);
    watch(60, 18, 1'b1, 1'b0, 64'hFFFFFFFF, 64'd2, -1, 1'b0);

    // Reset at cycle 10 of a divide aborts it with no done pulse.
    do_reset();
    run_op(1'b1, 1'b0, 64'd5, 64'd5);
    launch(1'b0, 1'b1, 64'hFFFFFFF9, 64'd2);
`ifdef MULTDIV_DIV_EN
    watch(50, -1, 1'b0, 1'b0, 64'd0, 64'd0, 10, 1'b1);
`else
    exp_q.push_back(64'd0); cyc_q.push_back(2);
    watch(50, -1, 1'b0, 1'b0, 64'd0, 64'd0, 10, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
